// File: rtl/coherence_cache_pkg.sv
// Shared cache-transfer types: writeback/refill FSM state encodings and the
// line-offset helper used to align byte addresses to cache-line boundaries.
package coherence_cache_pkg;

  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_DONE} xfer_wstate_t;
  typedef enum logic [2:0] {R_IDLE, R_WAIT, R_ADDR, R_DATA, R_DONE} xfer_rstate_t;

  // Number of low byte-address bits that fall inside one cache line.
  function automatic int line_offset(input int word_per_line, input int byte_per_word);
    return $clog2(word_per_line * byte_per_word);
  endfunction

endpackage

// File: rtl/cache_line_xfer_engine.sv
// Per-cache line transfer engine: one writeback line and one refill line as
// concurrent AXI4-style beat streams. Optional macro CACHE_XFER_WB_FWD_EN.
module cache_line_xfer_engine
  import coherence_cache_pkg::*;
#(
  parameter int ADDR_BITS      = 32,
  parameter int WORD_PER_LINE  = 8,
  parameter int BYTE_PER_WORD  = 4,
  parameter int DATA_WIDTH     = BYTE_PER_WORD * 8,
  parameter int LINE_BITS_SIZE = WORD_PER_LINE * DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_req,
  input  logic [ADDR_BITS-1:0]      wb_addr,
  input  logic [LINE_BITS_SIZE-1:0] wb_line,
  output logic                      wb_done,
  input  logic                      rf_req,
  input  logic [ADDR_BITS-1:0]      rf_addr,
  output logic [LINE_BITS_SIZE-1:0] rf_line,
  output logic                      rf_done,
  output logic                      c_awvalid,
  input  logic                      c_awready,
  output logic [ADDR_BITS-1:0]      c_awaddr,
  output logic                      c_wvalid,
  input  logic                      c_wready,
  output logic [DATA_WIDTH-1:0]     c_wdata,
  output logic                      c_arvalid,
  input  logic                      c_arready,
  output logic [7:0]                c_arlen,
  output logic [ADDR_BITS-1:0]      c_araddr,
  input  logic                      c_rvalid,
  output logic                      c_rready,
  input  logic [DATA_WIDTH-1:0]     c_rdata
);

  localparam int OFF       = line_offset(WORD_PER_LINE, BYTE_PER_WORD);
  localparam int WORD_BITS = $clog2(WORD_PER_LINE);
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(WORD_PER_LINE - 1);

  function automatic logic [ADDR_BITS-1:0] align_addr(input logic [ADDR_BITS-1:0] a);
    return {a[ADDR_BITS-1:OFF], {OFF{1'b0}}};
  endfunction

  xfer_wstate_t              wstate_q, wstate_d;
  logic [ADDR_BITS-1:0]      waddr_q, waddr_d;
  logic [LINE_BITS_SIZE-1:0] wline_q, wline_d;
  logic [WORD_BITS-1:0]      wbeat_q, wbeat_d;
  logic                      aw_done_q, aw_done_d;
  logic                      wd_done_q, wd_done_d;

  xfer_rstate_t              rstate_q, rstate_d;
  logic [ADDR_BITS-1:0]      raddr_q, raddr_d;
  logic [LINE_BITS_SIZE-1:0] rline_q, rline_d;
  logic [WORD_BITS-1:0]      rbeat_q, rbeat_d;

  logic aw_hs, w_hs, w_last;
  logic wb_active, wb_taking, rf_conflict;
  logic [ADDR_BITS-1:0] rf_aligned;

  assign c_awvalid = (wstate_q == W_BUSY) && !aw_done_q;
  assign c_wvalid  = (wstate_q == W_BUSY) && !wd_done_q;
  assign c_awaddr  = waddr_q;
  assign c_wdata   = wline_q[wbeat_q*DATA_WIDTH +: DATA_WIDTH];
  assign wb_done   = (wstate_q == W_DONE);

  assign c_arvalid = (rstate_q == R_ADDR);
  assign c_rready  = (rstate_q == R_DATA);
  assign c_araddr  = raddr_q;
  assign c_arlen   = 8'(WORD_PER_LINE - 1);
  assign rf_line   = rline_q;
  assign rf_done   = (rstate_q == R_DONE);

  assign aw_hs  = c_awvalid && c_awready;
  assign w_hs   = c_wvalid && c_wready;
  assign w_last = w_hs && (wbeat_q == LAST_BEAT);

  // Write FSM: address and data channels finish independently, in any order.
  always_comb begin
    wstate_d  = wstate_q;
    waddr_d   = waddr_q;
    wline_d   = wline_q;
    wbeat_d   = wbeat_q;
    aw_done_d = aw_done_q;
    wd_done_d = wd_done_q;
    case (wstate_q)
      W_IDLE: begin
        if (wb_req) begin
          waddr_d   = align_addr(wb_addr);
          wline_d   = wb_line;
          wbeat_d   = '0;
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
          wstate_d  = W_BUSY;
        end
      end
      W_BUSY: begin
        if (aw_hs)  aw_done_d = 1'b1;
        if (w_hs)   wbeat_d   = wbeat_q + 1'b1;
        if (w_last) wd_done_d = 1'b1;
        if ((aw_done_q || aw_hs) && (wd_done_q || w_last)) wstate_d = W_DONE;
      end
      W_DONE: begin
        aw_done_d = 1'b0;
        wd_done_d = 1'b0;
        wstate_d  = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // A refill to the line being written back (or captured this same cycle)
  // must not overtake the writeback.
  assign wb_active   = (wstate_q != W_IDLE);
  assign wb_taking   = (wstate_q == W_IDLE) && wb_req;
  assign rf_aligned  = align_addr(rf_addr);
  assign rf_conflict = (wb_active && (rf_aligned == waddr_q)) ||
                       (wb_taking && (rf_aligned == align_addr(wb_addr)));

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rline_d  = rline_q;
    rbeat_d  = rbeat_q;
    case (rstate_q)
      R_IDLE: begin
        if (rf_req) begin
          raddr_d = rf_aligned;
          rbeat_d = '0;
          if (rf_conflict) begin
`ifdef CACHE_XFER_WB_FWD_EN
            rline_d  = wb_active ? wline_q : wb_line;
            rstate_d = R_DONE;
`else
            rstate_d = R_WAIT;
`endif
          end else begin
            rstate_d = R_ADDR;
          end
        end
      end
      R_WAIT: if (wstate_q == W_IDLE) rstate_d = R_ADDR;
      R_ADDR: if (c_arready) rstate_d = R_DATA;
      R_DATA: begin
        if (c_rvalid) begin
          rline_d[rbeat_q*DATA_WIDTH +: DATA_WIDTH] = c_rdata;
          rbeat_d = rbeat_q + 1'b1;
          if (rbeat_q == LAST_BEAT) rstate_d = R_DONE;
        end
      end
      R_DONE:  rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wline_q   <= '0;
      wbeat_q   <= '0;
      aw_done_q <= 1'b0;
      wd_done_q <= 1'b0;
      rstate_q  <= R_IDLE;
      raddr_q   <= '0;
      rline_q   <= '0;
      rbeat_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      waddr_q   <= waddr_d;
      wline_q   <= wline_d;
      wbeat_q   <= wbeat_d;
      aw_done_q <= aw_done_d;
      wd_done_q <= wd_done_d;
      rstate_q  <= rstate_d;
      raddr_q   <= raddr_d;
      rline_q   <= rline_d;
      rbeat_q   <= rbeat_d;
    end
  end

endmodule

// File: tb/tb_cache_line_xfer_engine.sv
// Testbench for cache_line_xfer_engine: randomized AXI-style slaves and a
// line-level reference model of expected beats, addresses, lines and latencies.
module tb_cache_line_xfer_engine;

  localparam int AB  = 32;
  localparam int WPL = 8;
  localparam int BPW = 4;
  localparam int DW  = BPW * 8;
  localparam int LW  = WPL * DW;
  localparam logic [AB-1:0] LMASK = AB'(WPL * BPW - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_req, rf_req, wb_done, rf_done;
  logic [AB-1:0] wb_addr, rf_addr, c_awaddr, c_araddr;
  logic [LW-1:0] wb_line, rf_line;
  logic          c_awvalid, c_awready, c_wvalid, c_wready;
  logic          c_arvalid, c_arready, c_rvalid, c_rready;
  logic [DW-1:0] c_wdata, c_rdata;
  logic [7:0]    c_arlen;

  always #5 clk = ~clk;

  cache_line_xfer_engine #(
    .ADDR_BITS(AB), .WORD_PER_LINE(WPL), .BYTE_PER_WORD(BPW)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line), .wb_done(wb_done),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_line(rf_line), .rf_done(rf_done),
    .c_awvalid(c_awvalid), .c_awready(c_awready), .c_awaddr(c_awaddr),
    .c_wvalid(c_wvalid), .c_wready(c_wready), .c_wdata(c_wdata),
    .c_arvalid(c_arvalid), .c_arready(c_arready), .c_arlen(c_arlen),
    .c_araddr(c_araddr), .c_rvalid(c_rvalid), .c_rready(c_rready), .c_rdata(c_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by run_xfer
  logic [AB-1:0] obs_awaddr, obs_araddr;
  logic [LW-1:0] obs_rf_line;
  logic [DW-1:0] obs_w[$];
  int obs_aw_cnt, obs_ar_cnt, obs_ar_first, obs_junk_acc, obs_rbeats;
  int obs_wb_done_cnt, obs_wb_done_cyc, obs_rf_done_cnt, obs_rf_done_cyc;
  bit obs_timeout;
  logic [DW-1:0] slave_words[WPL];

  // Drives one writeback and/or one refill and plays the AXI slave side.
  // Cycle 1 is the first cycle wb_req is high; refill starts at cycle 1+rf_delay.
  task automatic run_xfer(input bit do_wb, input logic [AB-1:0] wa, input logic [LW-1:0] wl,
                          input bit do_rf, input logic [AB-1:0] ra, input int rf_delay,
                          input int wr_mode, input int aw_mode, input int ar_delay,
                          input int rv_mode, input int stop_rbeat, input int max_cyc);
    int ar_wait, sent, tail;
    bit aw_pulsed, wtog, ar_acc, done_all;
    ar_wait = 0; sent = 0; tail = -1; aw_pulsed = 0; wtog = 1; ar_acc = 0; done_all = 0;
    obs_w.delete();
    obs_aw_cnt = 0; obs_ar_cnt = 0; obs_ar_first = -1; obs_junk_acc = 0; obs_rbeats = 0;
    obs_wb_done_cnt = 0; obs_wb_done_cyc = -1; obs_rf_done_cnt = 0; obs_rf_done_cyc = -1;
    obs_rf_line = '0; obs_awaddr = '0; obs_araddr = '0;
    wb_req = do_wb; wb_addr = wa; wb_line = wl;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (stop_rbeat >= 0 && sent == stop_rbeat) break;
      if (do_rf && cyc == 1 + rf_delay) begin rf_req = 1'b1; rf_addr = ra; end
      if (wb_done) begin obs_wb_done_cnt++; obs_wb_done_cyc = cyc; wb_req = 1'b0; end
      if (rf_done) begin obs_rf_done_cnt++; obs_rf_done_cyc = cyc; obs_rf_line = rf_line; rf_req = 1'b0; end
      case (wr_mode)
        0:       c_wready = 1'b1;
        1:       begin c_wready = wtog; wtog = !wtog; end
        default: c_wready = 1'($urandom_range(0, 1));
      endcase
      case (aw_mode)
        0: c_awready = 1'b1;
        1: begin
          c_awready = !aw_pulsed && (obs_w.size() == WPL);
          if (c_awready) aw_pulsed = 1'b1;
        end
        default: c_awready = 1'($urandom_range(0, 1));
      endcase
      if (c_awvalid && c_awready) begin obs_aw_cnt++; obs_awaddr = c_awaddr; end
      if (c_wvalid && c_wready) obs_w.push_back(c_wdata);
      if (ar_acc && sent < WPL) begin
        c_rvalid = (rv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        c_rdata  = slave_words[sent];
      end else begin
        c_rvalid = 1'($urandom_range(0, 1));
        c_rdata  = $urandom;
      end
      if (c_rvalid && c_rready) begin
        if (ar_acc && sent < WPL) sent++;
        else obs_junk_acc++;
      end
      if (c_arvalid) begin
        if (obs_ar_first < 0) obs_ar_first = cyc;
        c_arready = (ar_wait >= ar_delay);
        ar_wait++;
        if (c_arready) begin obs_ar_cnt++; obs_araddr = c_araddr; ar_acc = 1'b1; end
      end else begin
        c_arready = 1'($urandom_range(0, 1));
      end
      obs_rbeats = sent;
      done_all = (!do_wb || obs_wb_done_cnt > 0) && (!do_rf || obs_rf_done_cnt > 0);
      if (done_all && tail < 0) tail = 3;
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(negedge clk);
    end
    obs_timeout = (stop_rbeat < 0) && !done_all;
    c_awready = 1'b0; c_wready = 1'b0; c_arready = 1'b0; c_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_req = 0; rf_req = 0; wb_addr = '0; rf_addr = '0; wb_line = '0;
    c_awready = 0; c_wready = 0; c_arready = 0; c_rvalid = 0; c_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({c_awvalid, c_wvalid, c_arvalid, c_rready, wb_done, rf_done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000",
                         {c_awvalid, c_wvalid, c_arvalid, c_rready, wb_done, rf_done});
    end
    n_checks++;
    if ({c_awaddr, c_araddr, c_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h/%h/%h required 0", c_awaddr, c_araddr, c_wdata);
    end
    n_checks++;
    if (rf_line !== '0) begin n_fail++; $display("FAIL reset_rf_line: got %h required 0", rf_line); end
    n_checks++;
    if (c_arlen !== 8'(WPL - 1)) begin n_fail++; $display("FAIL arlen: got %0d required %0d", c_arlen, WPL - 1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_writeback();
    logic [LW-1:0] wl;
    for (int k = 0; k < WPL; k++) wl[k*DW +: DW] = DW'(k);
    run_xfer(1, 32'h1234, wl, 0, '0, 0, 0, 0, 0, 0, -1, 100);
    n_checks++;
    if (obs_timeout) begin n_fail++; $display("FAIL wb_timeout: got timeout required wb_done"); end
    n_checks++;
    if (obs_awaddr !== 32'h1220 || obs_aw_cnt != 1) begin
      n_fail++; $display("FAIL wb_awaddr: got %h x%0d required 00001220 x1", obs_awaddr, obs_aw_cnt);
    end
    n_checks++;
    if (obs_w.size() != WPL) begin n_fail++; $display("FAIL wb_beats: got %0d required %0d", obs_w.size(), WPL); end
    for (int k = 0; k < WPL && k < obs_w.size(); k++) begin
      n_checks++;
      if (obs_w[k] !== DW'(k)) begin n_fail++; $display("FAIL wb_wdata[%0d]: got %h required %h", k, obs_w[k], k); end
    end
    n_checks++;
    if (obs_wb_done_cyc != 2 + WPL || obs_wb_done_cnt != 1) begin
      n_fail++; $display("FAIL wb_done_latency: got cycle %0d x%0d required cycle %0d x1",
                         obs_wb_done_cyc, obs_wb_done_cnt, 2 + WPL);
    end
  endtask

  task automatic test_refill();
    logic [LW-1:0] exp_line;
    for (int k = 0; k < WPL; k++) begin slave_words[k] = DW'(32'hA0 + k); exp_line[k*DW +: DW] = DW'(32'hA0 + k); end
    run_xfer(0, '0, '0, 1, 32'h40, 0, 0, 0, 3, 0, -1, 100);
    n_checks++;
    if (obs_timeout || obs_rf_done_cnt != 1) begin
      n_fail++; $display("FAIL rf_done_count: got %0d (timeout=%0b) required 1", obs_rf_done_cnt, obs_timeout);
    end
    n_checks++;
    if (obs_rf_line !== exp_line) begin n_fail++; $display("FAIL rf_line: got %h required %h", obs_rf_line, exp_line); end
    n_checks++;
    if (obs_araddr !== 32'h40 || obs_ar_cnt != 1) begin
      n_fail++; $display("FAIL rf_araddr: got %h x%0d required 00000040 x1", obs_araddr, obs_ar_cnt);
    end
    n_checks++;
    if (obs_rf_done_cyc != 3 + WPL + 3) begin
      n_fail++; $display("FAIL rf_latency: got %0d required %0d", obs_rf_done_cyc, 3 + WPL + 3);
    end
    n_checks++;
    if (obs_junk_acc != 0) begin n_fail++; $display("FAIL rf_extra_beat: got %0d accepted required 0", obs_junk_acc); end
  endtask

  // Refill to the line being written back: either waits for the writeback or
  // (forwarding build) takes the line straight from the writeback buffer.
  task automatic check_conflict_result(input string tag, input logic [LW-1:0] wl, input int rf_delay);
    logic [LW-1:0] exp_rd;
    for (int k = 0; k < WPL; k++) exp_rd[k*DW +: DW] = slave_words[k];
    n_checks++;
    if (obs_timeout || obs_wb_done_cnt != 1 || obs_rf_done_cnt != 1) begin
      n_fail++; $display("FAIL %s_dones: got wb x%0d rf x%0d timeout=%0b required 1/1", tag,
                         obs_wb_done_cnt, obs_rf_done_cnt, obs_timeout);
    end
`ifdef CACHE_XFER_WB_FWD_EN
    n_checks++;
    if (obs_ar_cnt != 0 || obs_ar_first != -1) begin
      n_fail++; $display("FAIL %s_fwd_no_ar: got %0d AR required 0", tag, obs_ar_cnt);
    end
    n_checks++;
    if (obs_rf_line !== wl) begin n_fail++; $display("FAIL %s_fwd_line: got %h required %h", tag, obs_rf_line, wl); end
    n_checks++;
    if (obs_rf_done_cyc != 2 + rf_delay) begin
      n_fail++; $display("FAIL %s_fwd_latency: got %0d required %0d", tag, obs_rf_done_cyc, 2 + rf_delay);
    end
`else
    n_checks++;
    if (obs_ar_first <= obs_wb_done_cyc) begin
      n_fail++; $display("FAIL %s_order: got first AR cycle %0d required after wb_done cycle %0d", tag,
                         obs_ar_first, obs_wb_done_cyc);
    end
    n_checks++;
    if (obs_rf_line !== exp_rd) begin n_fail++; $display("FAIL %s_line: got %h required %h", tag, obs_rf_line, exp_rd); end
    n_checks++;
    if (obs_rf_done_cyc <= rf_delay) begin n_fail++; $display("FAIL %s_rf_cycle: got %0d", tag, obs_rf_done_cyc); end
`endif
    n_checks++;
    if (obs_w.size() != WPL) begin n_fail++; $display("FAIL %s_wbeats: got %0d required %0d", tag, obs_w.size(), WPL); end
    for (int k = 0; k < WPL && k < obs_w.size(); k++) begin
      n_checks++;
      if (obs_w[k] !== wl[k*DW +: DW]) begin
        n_fail++; $display("FAIL %s_wdata[%0d]: got %h required %h", tag, k, obs_w[k], wl[k*DW +: DW]);
      end
    end
  endtask

  task automatic test_conflict();
    logic [LW-1:0] wl;
    for (int k = 0; k < WPL; k++) begin wl[k*DW +: DW] = $urandom; slave_words[k] = $urandom; end
    run_xfer(1, 32'h80, wl, 1, 32'h80, 0, 0, 0, 0, 0, -1, 200);
    check_conflict_result("conflict_same_cycle", wl, 0);
    n_checks++;
    if (obs_wb_done_cyc != 2 + WPL) begin
      n_fail++; $display("FAIL conflict_wb_latency: got %0d required %0d", obs_wb_done_cyc, 2 + WPL);
    end
    for (int k = 0; k < WPL; k++) begin wl[k*DW +: DW] = $urandom; slave_words[k] = $urandom; end
    run_xfer(1, 32'h3C0, wl, 1, 32'h3D4, 3, 0, 0, 0, 0, -1, 200);
    check_conflict_result("conflict_busy", wl, 3);
  endtask

  task automatic test_wready_toggle();
    logic [LW-1:0] wl;
    for (int k = 0; k < WPL; k++) wl[k*DW +: DW] = $urandom;
    run_xfer(1, 32'h5678, wl, 0, '0, 0, 1, 1, 0, 0, -1, 200);
    n_checks++;
    if (obs_timeout || obs_wb_done_cnt != 1 || obs_aw_cnt != 1) begin
      n_fail++; $display("FAIL toggle_done: got wb_done x%0d aw x%0d timeout=%0b required 1/1",
                         obs_wb_done_cnt, obs_aw_cnt, obs_timeout);
    end
    n_checks++;
    if (obs_awaddr !== 32'h5660) begin n_fail++; $display("FAIL toggle_awaddr: got %h required 00005660", obs_awaddr); end
    n_checks++;
    if (obs_w.size() != WPL) begin n_fail++; $display("FAIL toggle_beats: got %0d required %0d", obs_w.size(), WPL); end
    for (int k = 0; k < WPL && k < obs_w.size(); k++) begin
      n_checks++;
      if (obs_w[k] !== wl[k*DW +: DW]) begin
        n_fail++; $display("FAIL toggle_wdata[%0d]: got %h required %h", k, obs_w[k], wl[k*DW +: DW]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [LW-1:0] exp_line;
    for (int k = 0; k < WPL; k++) slave_words[k] = $urandom;
    run_xfer(0, '0, '0, 1, 32'h200, 0, 0, 0, 0, 0, 4, 100);
    n_checks++;
    if (obs_rbeats != 4) begin n_fail++; $display("FAIL abort_progress: got %0d beats required 4", obs_rbeats); end
    rf_req = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rf_done, c_rready, c_arvalid} !== 3'b0 || rf_line !== '0) begin
      n_fail++; $display("FAIL abort_reset_outputs: got %b line %h required 000 line 0",
                         {rf_done, c_rready, c_arvalid}, rf_line);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < WPL; k++) begin slave_words[k] = $urandom; exp_line[k*DW +: DW] = slave_words[k]; end
    run_xfer(0, '0, '0, 1, 32'h31C, 0, 0, 0, 0, 0, -1, 100);
    n_checks++;
    if (obs_timeout || obs_rf_done_cnt != 1 || obs_rf_done_cyc != 3 + WPL) begin
      n_fail++; $display("FAIL abort_refill: got done x%0d at %0d required x1 at %0d",
                         obs_rf_done_cnt, obs_rf_done_cyc, 3 + WPL);
    end
    n_checks++;
    if (obs_rf_line !== exp_line) begin n_fail++; $display("FAIL abort_line: got %h required %h", obs_rf_line, exp_line); end
    n_checks++;
    if (obs_araddr !== 32'h300) begin n_fail++; $display("FAIL abort_araddr: got %h required 00000300", obs_araddr); end
  endtask

  task automatic test_random();
    logic [LW-1:0] wl, exp_rd;
    logic [AB-1:0] wa, ra;
    int dly;
    for (int it = 0; it < 9; it++) begin
      for (int k = 0; k < WPL; k++) begin wl[k*DW +: DW] = $urandom; slave_words[k] = $urandom; end
      for (int k = 0; k < WPL; k++) exp_rd[k*DW +: DW] = slave_words[k];
      wa = $urandom;
      dly = $urandom_range(0, 5);
      if (it % 3 == 0) begin
        ra = wa ^ ($urandom & LMASK);
        run_xfer(1, wa, wl, 1, ra, dly, 2, 2, $urandom_range(0, 4), 2, -1, 400);
        check_conflict_result("rand_conflict", wl, dly);
      end else begin
        ra = $urandom;
        if (((ra ^ wa) & ~LMASK) == '0) ra = ra ^ 32'h100;
        run_xfer(1, wa, wl, 1, ra, dly, 2, 2, $urandom_range(0, 4), 2, -1, 400);
        n_checks++;
        if (obs_timeout || obs_wb_done_cnt != 1 || obs_rf_done_cnt != 1) begin
          n_fail++; $display("FAIL rand_dones: got wb x%0d rf x%0d timeout=%0b required 1/1",
                             obs_wb_done_cnt, obs_rf_done_cnt, obs_timeout);
        end
        n_checks++;
        if (obs_awaddr !== (wa & ~LMASK) || obs_araddr !== (ra & ~LMASK)) begin
          n_fail++; $display("FAIL rand_addr: got aw %h ar %h required %h %h", obs_awaddr, obs_araddr,
                             wa & ~LMASK, ra & ~LMASK);
        end
        n_checks++;
        if (obs_rf_line !== exp_rd) begin n_fail++; $display("FAIL rand_rf_line: got %h required %h", obs_rf_line, exp_rd); end
        n_checks++;
        if (obs_junk_acc != 0) begin n_fail++; $display("FAIL rand_extra_beat: got %0d required 0", obs_junk_acc); end
        n_checks++;
        if (obs_w.size() != WPL) begin n_fail++; $display("FAIL rand_wbeats: got %0d required %0d", obs_w.size(), WPL); end
        for (int k = 0; k < WPL && k < obs_w.size(); k++) begin
          n_checks++;
          if (obs_w[k] !== wl[k*DW +: DW]) begin
            n_fail++; $display("FAIL rand_wdata[%0d]: got %h required %h", k, obs_w[k], wl[k*DW +: DW]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_refill();
    test_conflict();
    test_wready_toggle();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
